// File: rtl/mem_pkg.sv
// Shared types for the byte-addressable memory access unit: data-type codes,
// FSM state encoding and the alignment rule applied when a request is accepted.
package mem_pkg;

  typedef enum logic [1:0] {
    DT_BYTE  = 2'b00,
    DT_HALF  = 2'b01,
    DT_WORD  = 2'b10,
    DT_DWORD = 2'b11
  } dt_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    HOLD   = 2'b11
  } state_e;

  localparam int LANES = 4;

  // Halfwords need an even address; words and doublewords need a multiple of four.
  function automatic logic is_aligned(input dt_e dt, input logic [1:0] addr_lo);
    case (dt)
      DT_BYTE: return 1'b1;
      DT_HALF: return ~addr_lo[0];
      default: return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Control-unit <-> memory bus: request fields in, completion strobe and data out.
interface mem_access_unit_if #(parameter int ADDR_W = 8);

  logic              mov;
  logic              r_w;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        dt;
  logic              sign_ext;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              moc;
  logic              beat;
  logic              fault;
  logic              busy;

  // Four-phase handshake: the master raises mov with stable request fields; the
  // request is taken at the first edge with mov=1 in IDLE. moc pulses for one
  // cycle per beat (beat qualifies it, fault flags misalignment). The master
  // must then drop mov for at least one edge before a new request is accepted.
  modport master (
    output mov, r_w, addr, dt, sign_ext, data_in,
    input  data_out, moc, beat, fault, busy
  );

  modport slave (
    input  mov, r_w, addr, dt, sign_ext, data_in,
    output data_out, moc, beat, fault, busy
  );

endinterface

// File: rtl/mem_byte_array.sv
// DEPTH x 8 byte storage with four consecutive lanes starting at base (lane 0 is
// the most significant byte); lane addresses wrap modulo DEPTH.
module mem_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     base,
  input  logic [3:0][7:0]       wdata,
  output logic [3:0][7:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]             mem [DEPTH];
  logic [3:0][ADDR_W-1:0] lane_addr;

  always_comb begin
    lane_addr = '0;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = base + ADDR_W'(i);
    end
  end

  // Storage is deliberately outside the reset domain so contents survive clr.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[lane_addr[i]] <= wdata[i];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < 4; i++) begin
        rdata[i] <= mem[lane_addr[i]];
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Clocked big-endian memory with MOV/MOC handshake, configurable wait states,
// sign/zero-extended sub-word reads, two-beat doublewords and alignment faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              clr,
  mem_access_unit_if.slave  bus,
  output state_e            state_dbg
);

  localparam int                CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam state_e            BEAT_START = (LATENCY > 0) ? WAIT : ACCESS;

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  dt_e               dt_q;
  logic              rw_q;
  logic              sext_q;
  logic [31:0]       data_q;
  logic              beat_q;
  logic              moc_q, beat_o_q, fault_q;
  dt_e               out_dt_q;
  logic              out_sext_q;

  logic              accept, aligned, access, last_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [31:0]       wword;
  logic [3:0]        we;
  logic              re;
  logic [3:0][7:0]   wdata;
  logic [3:0][7:0]   rdata;

  assign accept    = (state == IDLE) && bus.mov;
  assign aligned   = is_aligned(dt_e'(bus.dt), bus.addr[1:0]);
  assign access    = (state == ACCESS);
  assign last_beat = (dt_q != DT_DWORD) || beat_q;
  assign beat_addr = addr_q + (beat_q ? ADDR_W'(4) : ADDR_W'(0));
  // Beat-1 write data is taken live from the bus at its own access edge.
  assign wword     = beat_q ? bus.data_in : data_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.mov) state_nx = aligned ? BEAT_START : HOLD;
      WAIT:    if (cnt == CNT_LAST) state_nx = ACCESS;
      ACCESS:  state_nx = last_beat ? HOLD : BEAT_START;
      HOLD:    if (!bus.mov) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    we    = 4'b0000;
    re    = 1'b0;
    wdata = '0;
    for (int i = 0; i < 4; i++) begin
      wdata[i] = wword[31 - 8*i -: 8];
    end
    if (access) begin
      if (rw_q) begin
        re = 1'b1;
      end else begin
        case (dt_q)
          DT_BYTE: begin
            we       = 4'b0001;
            wdata[0] = wword[7:0];
          end
          DT_HALF: begin
            we       = 4'b0011;
            wdata[0] = wword[15:8];
            wdata[1] = wword[7:0];
          end
          default: we = 4'b1111;
        endcase
      end
    end
  end

  mem_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .clr   (clr),
    .we    (we),
    .re    (re),
    .base  (beat_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      dt_q       <= DT_BYTE;
      rw_q       <= 1'b0;
      sext_q     <= 1'b0;
      data_q     <= '0;
      beat_q     <= 1'b0;
      moc_q      <= 1'b0;
      beat_o_q   <= 1'b0;
      fault_q    <= 1'b0;
      out_dt_q   <= DT_BYTE;
      out_sext_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= (state == WAIT) ? cnt + CNT_W'(1) : '0;
      moc_q    <= access || (accept && !aligned);
      fault_q  <= accept && !aligned;
      beat_o_q <= access && beat_q;
      if (accept) begin
        addr_q <= bus.addr;
        dt_q   <= dt_e'(bus.dt);
        rw_q   <= bus.r_w;
        sext_q <= bus.sign_ext;
        data_q <= bus.data_in;
        beat_q <= 1'b0;
      end else if (access && !last_beat) begin
        beat_q <= 1'b1;
      end
      // Extension mode follows the read lanes so data_out holds across writes.
      if (access && rw_q) begin
        out_dt_q   <= dt_q;
        out_sext_q <= sext_q;
      end
    end
  end

  always_comb begin
    case (out_dt_q)
      DT_BYTE: bus.data_out = {{24{out_sext_q & rdata[0][7]}}, rdata[0]};
      DT_HALF: bus.data_out = {{16{out_sext_q & rdata[0][7]}}, rdata[0], rdata[1]};
      default: bus.data_out = {rdata[0], rdata[1], rdata[2], rdata[3]};
    endcase
  end

  assign bus.moc   = moc_q;
  assign bus.beat  = beat_o_q;
  assign bus.fault = fault_q;
  assign bus.busy  = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Drives three memory units (LATENCY 0, 1, 3) with identical requests and checks
// completion timing, fault, beat and read data against hand-computed values.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        mov, r_w, sign_ext;
  logic [7:0]  addr;
  logic [1:0]  dt;
  logic [31:0] data_in;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if #(.ADDR_W(8)) if0 ();
  mem_access_unit_if #(.ADDR_W(8)) if1 ();
  mem_access_unit_if #(.ADDR_W(8)) if3 ();

  assign {if0.mov, if0.r_w, if0.addr, if0.dt, if0.sign_ext, if0.data_in} = {mov, r_w, addr, dt, sign_ext, data_in};
  assign {if1.mov, if1.r_w, if1.addr, if1.dt, if1.sign_ext, if1.data_in} = {mov, r_w, addr, dt, sign_ext, data_in};
  assign {if3.mov, if3.r_w, if3.addr, if3.dt, if3.sign_ext, if3.data_in} = {mov, r_w, addr, dt, sign_ext, data_in};

  state_e st_o [3];

  mem_access_unit #(.ADDR_W(8), .LATENCY(0)) dut0 (.clk(clk), .clr(clr), .bus(if0), .state_dbg(st_o[0]));
  mem_access_unit #(.ADDR_W(8), .LATENCY(1)) dut1 (.clk(clk), .clr(clr), .bus(if1), .state_dbg(st_o[1]));
  mem_access_unit #(.ADDR_W(8), .LATENCY(3)) dut3 (.clk(clk), .clr(clr), .bus(if3), .state_dbg(st_o[2]));

  logic        moc_o [3], beat_o [3], fault_o [3], busy_o [3];
  logic [31:0] dout_o [3];
  int          lat_v [3] = '{0, 1, 3};

  assign moc_o   = '{if0.moc,      if1.moc,      if3.moc};
  assign beat_o  = '{if0.beat,     if1.beat,     if3.beat};
  assign fault_o = '{if0.fault,    if1.fault,    if3.fault};
  assign busy_o  = '{if0.busy,     if1.busy,     if3.busy};
  assign dout_o  = '{if0.data_out, if1.data_out, if3.data_out};

  typedef struct {
    logic        rw;
    logic [7:0]  a;
    logic [1:0]  d;
    logic        se;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        flt;
    logic [31:0] exp0;
    logic [31:0] exp1;
    int          hold;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  // Per-request observations, one slot per DUT.
  int          t0_r [3], t1_r [3], nmoc_r [3];
  logic        flt_r [3];
  logic [31:0] d0_r [3], d1_r [3];

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h", name, k, got, exp);
    end
  endtask

  task automatic observe();
    for (int k = 0; k < 3; k++) begin
      if (moc_o[k]) begin
        nmoc_r[k]++;
        if (!beat_o[k] && t0_r[k] < 0) begin
          t0_r[k]  = cyc;
          d0_r[k]  = dout_o[k];
          flt_r[k] = fault_o[k];
        end else if (beat_o[k] && t1_r[k] < 0) begin
          t1_r[k] = cyc;
          d1_r[k] = dout_o[k];
        end
      end
    end
  endtask

  task automatic do_req(input vec_t v);
    int  e_acc;
    bit  all_hold;
    @(negedge clk);
    mov = 1'b1; r_w = v.rw; addr = v.a; dt = v.d; sign_ext = v.se; data_in = v.w0;
    e_acc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      t0_r[k] = -1; t1_r[k] = -1; nmoc_r[k] = 0; flt_r[k] = 1'b0;
      d0_r[k] = 32'hx; d1_r[k] = 32'hx;
    end
    @(negedge clk);
    data_in = v.w1;
    for (int n = 0; n < 60; n++) begin
      observe();
      all_hold = 1'b1;
      for (int k = 0; k < 3; k++) if (st_o[k] != HOLD) all_hold = 1'b0;
      if (all_hold) break;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk("reach_hold", k, 32'(st_o[k]), 32'(HOLD));
      if (t0_r[k] >= 0) t0_r[k] = t0_r[k] - e_acc;
      if (t1_r[k] >= 0) t1_r[k] = t1_r[k] - e_acc;
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      observe();
      for (int k = 0; k < 3; k++) chk("busy_in_hold", k, 32'(busy_o[k]), 32'd1);
    end
    mov = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("busy_after_release", k, 32'(busy_o[k]), 32'd0);
      chk("idle_after_release", k, 32'(st_o[k]), 32'(IDLE));
    end
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    bit two;
    two = (v.d == DT_DWORD) && !v.flt;
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_moc_edge"}, k, 32'(t0_r[k]), v.flt ? 32'd0 : 32'(lat_v[k] + 1));
      chk({tag, "_fault"},    k, 32'(flt_r[k]), 32'(v.flt));
      chk({tag, "_data0"},    k, d0_r[k], v.exp0);
      chk({tag, "_moc_count"}, k, 32'(nmoc_r[k]), two ? 32'd2 : 32'd1);
      if (two) begin
        chk({tag, "_beat1_edge"}, k, 32'(t1_r[k]), 32'(2 * (lat_v[k] + 1)));
        chk({tag, "_data1"},      k, d1_r[k], v.exp1);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_moc"},   k, 32'(moc_o[k]),   32'd0);
      chk({tag, "_fault"}, k, 32'(fault_o[k]), 32'd0);
      chk({tag, "_beat"},  k, 32'(beat_o[k]),  32'd0);
      chk({tag, "_busy"},  k, 32'(busy_o[k]),  32'd0);
      chk({tag, "_data"},  k, dout_o[k],       32'd0);
      chk({tag, "_state"}, k, 32'(st_o[k]),    32'(IDLE));
    end
  endtask

  initial begin
    vec_t v;
    //           rw    addr   dt        se    w0            w1            flt   exp0          exp1          hold
    vecs[0]  = '{1'b0, 8'h10, DT_WORD,  1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 32'h00000000, 32'h0,        0};
    vecs[1]  = '{1'b1, 8'h10, DT_WORD,  1'b0, 32'h0,        32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        5};
    vecs[2]  = '{1'b1, 8'h11, DT_BYTE,  1'b1, 32'h0,        32'h0,        1'b0, 32'hFFFFFFAD, 32'h0,        0};
    vecs[3]  = '{1'b1, 8'h12, DT_HALF,  1'b0, 32'h0,        32'h0,        1'b0, 32'h0000BEEF, 32'h0,        0};
    vecs[4]  = '{1'b1, 8'h12, DT_HALF,  1'b1, 32'h0,        32'h0,        1'b0, 32'hFFFFBEEF, 32'h0,        0};
    vecs[5]  = '{1'b1, 8'h11, DT_HALF,  1'b0, 32'h0,        32'h0,        1'b1, 32'hFFFFBEEF, 32'h0,        0};
    vecs[6]  = '{1'b1, 8'h10, DT_WORD,  1'b0, 32'h0,        32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        0};
    vecs[7]  = '{1'b0, 8'hFC, DT_DWORD, 1'b0, 32'h11223344, 32'h55667788, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[8]  = '{1'b1, 8'hFC, DT_WORD,  1'b0, 32'h0,        32'h0,        1'b0, 32'h11223344, 32'h0,        0};
    vecs[9]  = '{1'b1, 8'h00, DT_WORD,  1'b0, 32'h0,        32'h0,        1'b0, 32'h55667788, 32'h0,        0};
    vecs[10] = '{1'b1, 8'hFF, DT_BYTE,  1'b0, 32'h0,        32'h0,        1'b0, 32'h00000044, 32'h0,        0};
    vecs[11] = '{1'b0, 8'h13, DT_BYTE,  1'b0, 32'h12345680, 32'h0,        1'b0, 32'h00000044, 32'h0,        0};
    vecs[12] = '{1'b1, 8'h13, DT_BYTE,  1'b1, 32'h0,        32'h0,        1'b0, 32'hFFFFFF80, 32'h0,        0};
    vecs[13] = '{1'b1, 8'h10, DT_WORD,  1'b1, 32'h0,        32'h0,        1'b0, 32'hDEADBE80, 32'h0,        0};
    vecs[14] = '{1'b1, 8'h12, DT_WORD,  1'b0, 32'h0,        32'h0,        1'b1, 32'hDEADBE80, 32'h0,        0};
    vecs[15] = '{1'b0, 8'h20, DT_WORD,  1'b0, 32'hCAFEF00D, 32'h0,        1'b0, 32'hDEADBE80, 32'h0,        0};
    vecs[16] = '{1'b1, 8'hFC, DT_DWORD, 1'b0, 32'h0,        32'h0,        1'b0, 32'h11223344, 32'h55667788, 0};
    vecs[17] = '{1'b0, 8'h0E, DT_HALF,  1'b0, 32'hFFFF1234, 32'h0,        1'b0, 32'h55667788, 32'h0,        0};
    vecs[18] = '{1'b1, 8'h0E, DT_HALF,  1'b1, 32'h0,        32'h0,        1'b0, 32'h00001234, 32'h0,        0};
    vecs[19] = '{1'b0, 8'h06, DT_DWORD, 1'b0, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b1, 32'h00001234, 32'h0,        0};
    vecs[20] = '{1'b1, 8'h10, DT_BYTE,  1'b1, 32'h0,        32'h0,        1'b0, 32'hFFFFFFDE, 32'h0,        0};

    clr = 1'b0; mov = 1'b0; r_w = 1'b0; addr = '0; dt = '0; sign_ext = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    clr = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i]);
      check_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a write to 0x20: the write must be discarded.
    @(negedge clk);
    mov = 1'b1; r_w = 1'b0; addr = 8'h20; dt = DT_WORD; sign_ext = 1'b0; data_in = 32'h12345678;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_reset("midclr");
    mov = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    v = '{1'b1, 8'h20, DT_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, 32'h0, 0};
    do_req(v);
    check_vec(v, "postclr_word");
    v = '{1'b1, 8'h23, DT_BYTE, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000000D, 32'h0, 0};
    do_req(v);
    check_vec(v, "postclr_byte");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, clocked successor to the 256x8 byte memory: a byte-addressable, big-endian data/instruction store with a four-phase MOV/MOC handshake, configurable access latency, sign/zero-extended sub-word reads, automatic two-beat doubleword transfers and alignment-fault reporting. It sits between the control unit (MOV, R/W, DT) and the MAR/MDR/IR registers of the CPU datapath.

## Interface
- ADDR_W, 8: byte-address width; DEPTH = 2**ADDR_W bytes.
- LATENCY, 1: wait cycles inserted before each beat's array access (0 allowed).
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- mov  in  1  memory-operation-valid level from control unit.
- r_w  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  byte address (from MAR).
- dt  in  2  data type: 00 byte, 01 halfword, 10 word, 11 doubleword.
- sign_ext  in  1  read only: 1 = sign-extend byte/halfword, 0 = zero-extend.
- data_in  in  32  write data (from MDR).
- data_out  out  32  read data, registered.
- moc  out  1  memory-operation-complete, one-cycle pulse per beat.
- beat  out  1  beat index qualifying moc (0 first word, 1 second doubleword word).
- fault  out  1  alignment fault, valid with moc.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, HOLD.
- IDLE: mov=1 at an edge accepts request; latches addr, dt, r_w, sign_ext, and data_in (beat-0 write data). Next state WAIT (LATENCY>0) or ACCESS.
- Alignment check at acceptance: halfword needs addr[0]=0; word/doubleword need addr[1:0]=0. Misaligned -> go directly to HOLD, moc=1, fault=1 for one cycle; no array write, data_out unchanged.
- WAIT: counter counts LATENCY cycles, then ACCESS.
- ACCESS (one cycle): performs beat at edge leaving it; moc=1, beat set, in following cycle.
  - Read byte: {24 ext, mem[a]}; halfword: {16 ext, mem[a], mem[a+1]}; word/dword beat: {mem[a], mem[a+1], mem[a+2], mem[a+3]}. ext = replicated MSB when sign_ext=1, else 0; sign_ext ignored for word/dword.
  - Write byte: mem[a]<=data_in[7:0]; halfword: data_in[15:8], data_in[7:0] to a, a+1; word: data_in[31:24]..[7:0] to a..a+3.
  - Doubleword: beat 0 at latched addr, beat 1 at addr+4; after beat 0 return to WAIT/ACCESS for beat 1. Beat-1 write data sampled from data_in at the beat-1 access edge.
- Address arithmetic modulo DEPTH: addr+4 and byte lanes wrap to 0.
- HOLD: entered after final beat (or fault); returns to IDLE only when mov=0 at an edge. mov held high after completion never retriggers.
- mov dropped mid-transfer is ignored; transfer completes.

## Timing
- Reset (clr=0, asynchronous): state IDLE, moc=0, fault=0, beat=0, busy=0, data_out=0, counter=0. Array contents not reset, not modified. In-flight access whose ACCESS edge has not occurred is discarded.
- Request accepted at edge E0: single-beat moc high in cycle after edge E0+LATENCY+1; doubleword beat-1 moc after edge E0+2(LATENCY+1).
- Fault: moc=fault=1 in cycle after E0.
- data_out updates at the same edge moc rises; holds until next read beat or reset.
- Minimum back-to-back: one mov=0 cycle seen in HOLD, then IDLE accepts next request.
- busy rises at E0+ (cycle after acceptance), falls on HOLD->IDLE edge.

## Structure
- Shared package mem_pkg: DT encodings (DT_BYTE, DT_HALF, DT_WORD, DT_DWORD), state enum, alignment-check function.
- Sub-module mem_byte_array: DEPTH x 8 storage, four byte-lane write enables, four registered read lanes, wrapped lane addressing; FSM, latency counter, extension and packing in mem_access_unit.

## Test plan
- LATENCY=1: write word 0xDEADBEEF at 0x10, read word at 0x10 -> moc at E0+2 each, data_out=0xDEADBEEF; byte read 0x11 sign_ext=1 -> 0xFFFFFFAD.
- Halfword read 0x12 sign_ext=0 -> 0x0000BEEF; sign_ext=1 -> 0xFFFFBEEF; halfword read 0x11 -> moc+fault at E0+1, data_out unchanged, memory unchanged.
- Doubleword write 0x11223344/0x55667788 at 0xFC (ADDR_W=8) -> beat-0 moc at E0+2, beat-1 at E0+4; word read 0x00 -> 0x55667788 (wrap).
- mov held high 5 cycles after moc -> exactly one access, busy stays high until mov=0 edge, then IDLE.
- clr pulsed low during WAIT of a write to 0x20 -> outputs zero immediately, mem[0x20..0x23] retain prior values, next request completes normally.
- LATENCY=0: word read moc at E0+1; LATENCY=3: moc at E0+4.
